// File: rtl/mips_pkg.sv
// Shared MIPS encodings (opcodes, functs, request kinds, loader states) used by
// the encoder and by the main/ALU decoders so the two sides cannot drift apart.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   // Codes 11-15 are illegal request kinds.
   typedef enum logic [3:0] {
      K_NOP  = 4'd0,
      K_ADD  = 4'd1,
      K_SUB  = 4'd2,
      K_AND  = 4'd3,
      K_OR   = 4'd4,
      K_SLT  = 4'd5,
      K_LW   = 4'd6,
      K_SW   = 4'd7,
      K_BEQ  = 4'd8,
      K_ADDI = 4'd9,
      K_J    = 4'd10
   } kind_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/enc_fifo.sv
// Synchronous FIFO for encoded words; head is visible the cycle after the first push.
// Push is ignored when full, pop is ignored when empty; push and pop may coincide.
module enc_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wp;
   logic [AW:0]      rp;
   logic             do_push;
   logic             do_pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty   = (wp == rp);
   assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rp[AW-1:0]];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop)  rp <= rp + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wp[AW-1:0]] <= push_dat;
   end

endmodule

// File: rtl/mips_instr_encoder.sv
// Program loader: encodes instruction requests into MIPS words and streams them to imem.
// One-cycle accept-to-write latency when idle; req_ready drops while the word FIFO is full.
module mips_instr_encoder
   import mips_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base,
   input  logic              finish,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_kind,
   input  logic [4:0]        req_rs,
   input  logic [4:0]        req_rt,
   input  logic [4:0]        req_rd,
   input  logic [15:0]       req_imm,
   input  logic [25:0]       req_target,
   output logic              imem_we,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wd,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              wrapped
);

   function automatic logic [31:0] encode(input logic [3:0]  kind,
                                          input logic [4:0]  rs,
                                          input logic [4:0]  rt,
                                          input logic [4:0]  rd,
                                          input logic [15:0] imm,
                                          input logic [25:0] target);
      logic [31:0] w;
      w = '0;
      case (kind)
         K_ADD:   w = {OP_RTYPE, rs, rt, rd, 5'b0, FUNCT_ADD};
         K_SUB:   w = {OP_RTYPE, rs, rt, rd, 5'b0, FUNCT_SUB};
         K_AND:   w = {OP_RTYPE, rs, rt, rd, 5'b0, FUNCT_AND};
         K_OR:    w = {OP_RTYPE, rs, rt, rd, 5'b0, FUNCT_OR};
         K_SLT:   w = {OP_RTYPE, rs, rt, rd, 5'b0, FUNCT_SLT};
         K_LW:    w = {OP_LW, rs, rt, imm};
         K_SW:    w = {OP_SW, rs, rt, imm};
         K_BEQ:   w = {OP_BEQ, rs, rt, imm};
         K_ADDI:  w = {OP_ADDI, rs, rt, imm};
         K_J:     w = {OP_J, target};
         default: w = '0;
      endcase
      return w;
   endfunction

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] addr;
   logic              fifo_full;
   logic              fifo_empty;
   logic [31:0]       fifo_head;
   logic              accept;
   logic              legal;
   logic              push;
   logic              pop;

   assign req_ready = (state == LOAD) & ~fifo_full;
   assign accept    = req_valid & req_ready;
   assign legal     = (req_kind <= K_J);
   assign push      = accept & legal;
   assign imem_we   = ~fifo_empty;
   assign pop       = imem_we & wr_ready;
   assign imem_addr = addr;
   // Stale head contents are hidden while nothing is queued.
   assign imem_wd   = imem_we ? fifo_head : '0;
   assign busy      = (state == LOAD) | (state == DRAIN);
   assign done      = (state == DONE);

   enc_fifo #(
      .WIDTH (32),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .push_dat (encode(req_kind, req_rs, req_rt, req_rd, req_imm, req_target)),
      .pop      (pop),
      .head     (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // DRAIN never accepts, so an empty FIFO also means no write this cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)      state_nxt = LOAD;
         LOAD:    if (finish)     state_nxt = DRAIN;
         DRAIN:   if (fifo_empty) state_nxt = DONE;
         DONE:                    state_nxt = IDLE;
         default:                 state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr    <= '0;
         err     <= 1'b0;
         wrapped <= 1'b0;
      end else if ((state == IDLE) && start) begin
         addr    <= base;
         err     <= 1'b0;
         wrapped <= 1'b0;
      end else begin
         if (accept && !legal) err <= 1'b1;
         if (pop) begin
            addr <= addr + 1'b1;
            if (&addr) wrapped <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: directed scenarios plus randomized
// sessions scored against an arithmetic encoding model and an address/flag model.
module tb_mips_instr_encoder;

   logic        clk;
   logic        reset;
   logic        start;
   logic [5:0]  base;
   logic        finish;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_kind;
   logic [4:0]  req_rs;
   logic [4:0]  req_rt;
   logic [4:0]  req_rd;
   logic [15:0] req_imm;
   logic [25:0] req_target;
   logic        imem_we;
   logic        wr_ready;
   logic [5:0]  imem_addr;
   logic [31:0] imem_wd;
   logic        busy;
   logic        done;
   logic        err;
   logic        wrapped;

   int errors = 0;
   int checks = 0;
   int wr_mode = 0;

   logic [31:0] exp_wd[$];
   logic [5:0]  exp_addr[$];
   logic [31:0] got_wd[$];
   logic [5:0]  got_addr[$];
   logic [5:0]  m_addr;
   logic        m_err;
   logic        m_wrap;

   mips_instr_encoder #(.ADDR_W(6), .DEPTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .base       (base),
      .finish     (finish),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_kind   (req_kind),
      .req_rs     (req_rs),
      .req_rt     (req_rt),
      .req_rd     (req_rd),
      .req_imm    (req_imm),
      .req_target (req_target),
      .imem_we    (imem_we),
      .wr_ready   (wr_ready),
      .imem_addr  (imem_addr),
      .imem_wd    (imem_wd),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .wrapped    (wrapped)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // wr_ready: 0 = stall, 1 = always ready, 2 = random.
   initial begin
      wr_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (wr_mode == 0)      wr_ready = 1'b0;
         else if (wr_mode == 1) wr_ready = 1'b1;
         else                   wr_ready = 1'($urandom_range(0, 1));
      end
   end

   // Inputs only change just after the rising edge, so the negedge view is what commits.
   always @(negedge clk) begin
      if (reset === 1'b1 && imem_we === 1'b1 && wr_ready === 1'b1) begin
         got_wd.push_back(imem_wd);
         got_addr.push_back(imem_addr);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] ref_word(input longint k, input longint rs, input longint rt,
                                            input longint rd, input longint imm, input longint tgt);
      longint w;
      longint fn;
      longint op;
      w = 0;
      fn = 0;
      op = 0;
      if (k >= 1 && k <= 5) begin
         if (k == 1) fn = 32;
         else if (k == 2) fn = 34;
         else if (k == 3) fn = 36;
         else if (k == 4) fn = 37;
         else fn = 42;
         w = rs * 2097152 + rt * 65536 + rd * 2048 + fn;
      end else if (k >= 6 && k <= 9) begin
         if (k == 6) op = 35;
         else if (k == 7) op = 43;
         else if (k == 8) op = 4;
         else op = 8;
         w = op * 67108864 + rs * 2097152 + rt * 65536 + imm;
      end else if (k == 10) begin
         w = 2 * 67108864 + tgt;
      end
      return w[31:0];
   endfunction

   task automatic start_session(input logic [5:0] b, input logic with_finish);
      start = 1'b1;
      base = b;
      finish = with_finish;
      @(posedge clk);
      #1;
      start = 1'b0;
      finish = 1'b0;
      m_addr = b;
      m_err = 1'b0;
      m_wrap = 1'b0;
      exp_wd.delete();
      exp_addr.delete();
      got_wd.delete();
      got_addr.delete();
   endtask

   task automatic do_req(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
      bit acc;
      acc = 1'b0;
      req_kind = k;
      req_rs = rs;
      req_rt = rt;
      req_rd = rd;
      req_imm = imm;
      req_target = tgt;
      req_valid = 1'b1;
      for (int c = 0; c < 200 && !acc; c++) begin
         @(negedge clk);
         if (req_ready === 1'b1) acc = 1'b1;
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL req_accept: kind=%0d never accepted, required acceptance", k);
      end else if (k <= 4'd10) begin
         exp_wd.push_back(ref_word(longint'(k), longint'(rs), longint'(rt), longint'(rd),
                                   longint'(imm), longint'(tgt)));
         exp_addr.push_back(m_addr);
         if (m_addr == 6'h3F) m_wrap = 1'b1;
         m_addr = m_addr + 6'd1;
      end else begin
         m_err = 1'b1;
      end
   endtask

   task automatic end_session(output int width);
      int c;
      finish = 1'b1;
      @(posedge clk);
      #1;
      finish = 1'b0;
      width = 0;
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (done !== 1'b1 && c < 300);
      while (done === 1'b1 && width < 10) begin
         width++;
         @(negedge clk);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({imem_we, req_ready, busy, done, err, wrapped} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b required 000000", {imem_we, req_ready, busy, done, err, wrapped});
      end
      checks++;
      if (imem_addr !== 6'd0 || imem_wd !== 32'd0) begin
         errors++;
         $display("FAIL reset_bus: got addr=%0d wd=%h required 0/0", imem_addr, imem_wd);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || imem_we !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got busy=%b we=%b required 0/0", busy, imem_we);
      end
   endtask

   task automatic test_add;
      int w;
      wr_mode = 1;
      @(posedge clk);
      #1;
      start_session(6'd0, 1'b1);
      checks++;
      if (busy !== 1'b1 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL start_over_finish: got busy=%b rdy=%b required 1/1", busy, req_ready);
      end
      do_req(4'd1, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
      checks++;
      if (imem_we !== 1'b1 || imem_wd !== 32'h00221820 || imem_addr !== 6'd0) begin
         errors++;
         $display("FAIL add_latency: got we=%b wd=%h addr=%0d required 1/00221820/0", imem_we, imem_wd, imem_addr);
      end
      end_session(w);
      checks++;
      if (w !== 1) begin
         errors++;
         $display("FAIL add_done_width: got %0d required 1", w);
      end
      checks++;
      if (got_wd.size() != 1 || got_wd[0] !== 32'h00221820 || got_addr[0] !== 6'd0) begin
         errors++;
         $display("FAIL add_write: got %0d writes required one 00221820 at 0", got_wd.size());
      end
   endtask

   task automatic test_sequence;
      int w;
      logic [31:0] want[3];
      want[0] = 32'h8C080004;
      want[1] = 32'h1100FFFF;
      want[2] = 32'h08000010;
      start_session(6'd0, 1'b0);
      do_req(4'd6, 5'd0, 5'd8, 5'd0, 16'd4, 26'd0);
      do_req(4'd8, 5'd8, 5'd0, 5'd0, 16'hFFFF, 26'd0);
      do_req(4'd10, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10);
      end_session(w);
      checks++;
      if (got_wd.size() != 3) begin
         errors++;
         $display("FAIL seq_count: got %0d writes required 3", got_wd.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_wd[i] !== want[i] || got_addr[i] !== 6'(i)) begin
               errors++;
               $display("FAIL seq_word%0d: got %h@%0d required %h@%0d", i, got_wd[i], got_addr[i], want[i], i);
            end
         end
      end
   endtask

   task automatic test_backpressure;
      int w;
      wr_mode = 0;
      @(posedge clk);
      #1;
      start_session(6'd5, 1'b0);
      for (int i = 0; i < 4; i++)
         do_req(4'(1 + i), 5'(i), 5'(i + 1), 5'(i + 2), 16'd0, 26'd0);
      req_kind = 4'd9;
      req_rs = 5'd7;
      req_rt = 5'd9;
      req_imm = 16'h1234;
      req_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (req_ready !== 1'b0 || imem_we !== 1'b1 || imem_addr !== 6'd5 || imem_wd !== exp_wd[0]) begin
            errors++;
            $display("FAIL bp_stall: got rdy=%b we=%b addr=%0d wd=%h required 0/1/5/%h",
                     req_ready, imem_we, imem_addr, imem_wd, exp_wd[0]);
         end
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      wr_mode = 1;
      do_req(4'd9, 5'd7, 5'd9, 5'd0, 16'h1234, 26'd0);
      end_session(w);
      checks++;
      if (got_wd.size() != exp_wd.size()) begin
         errors++;
         $display("FAIL bp_count: got %0d writes required %0d", got_wd.size(), exp_wd.size());
      end else begin
         foreach (exp_wd[i]) begin
            checks++;
            if (got_wd[i] !== exp_wd[i] || got_addr[i] !== exp_addr[i]) begin
               errors++;
               $display("FAIL bp_word%0d: got %h@%0d required %h@%0d", i, got_wd[i], got_addr[i], exp_wd[i], exp_addr[i]);
            end
         end
      end
   endtask

   task automatic test_illegal;
      int w;
      start_session(6'd10, 1'b0);
      do_req(4'd1, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
      do_req(4'd12, 5'd4, 5'd4, 5'd4, 16'd4, 26'd4);
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL illegal_err: got %b required 1", err);
      end
      do_req(4'd2, 5'd4, 5'd5, 5'd6, 16'd0, 26'd0);
      end_session(w);
      checks++;
      if (got_wd.size() != 2 || err !== 1'b1) begin
         errors++;
         $display("FAIL illegal_count: got %0d writes err=%b required 2 writes err=1", got_wd.size(), err);
      end else begin
         foreach (exp_wd[i]) begin
            checks++;
            if (got_wd[i] !== exp_wd[i] || got_addr[i] !== 6'(10 + i)) begin
               errors++;
               $display("FAIL illegal_word%0d: got %h@%0d required %h@%0d", i, got_wd[i], got_addr[i], exp_wd[i], 10 + i);
            end
         end
      end
   endtask

   task automatic test_wrap;
      int w;
      start_session(6'd63, 1'b0);
      checks++;
      if (err !== 1'b0 || wrapped !== 1'b0) begin
         errors++;
         $display("FAIL start_clears: got err=%b wrapped=%b required 0/0", err, wrapped);
      end
      do_req(4'd9, 5'd3, 5'd4, 5'd0, 16'h00AA, 26'd0);
      do_req(4'd7, 5'd5, 5'd6, 5'd0, 16'h0BB0, 26'd0);
      end_session(w);
      checks++;
      if (got_wd.size() != 2 || got_addr[0] !== 6'd63 || got_addr[1] !== 6'd0) begin
         errors++;
         $display("FAIL wrap_addrs: got %0d writes required 2 at 63,0", got_wd.size());
      end
      checks++;
      if (wrapped !== 1'b1 || w !== 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL wrap_flags: got wrapped=%b done_width=%0d busy=%b required 1/1/0", wrapped, w, busy);
      end
   endtask

   task automatic test_reset_mid_drain;
      wr_mode = 0;
      @(posedge clk);
      #1;
      start_session(6'd20, 1'b0);
      for (int i = 0; i < 3; i++)
         do_req(4'd4, 5'(i), 5'(i), 5'(i), 16'd0, 26'd0);
      finish = 1'b1;
      @(posedge clk);
      #1;
      finish = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1 || imem_we !== 1'b1 || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL drain_state: got busy=%b we=%b rdy=%b required 1/1/0", busy, imem_we, req_ready);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (imem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: got we=%b busy=%b done=%b required 0/0/0", imem_we, busy, done);
      end
      wr_mode = 1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (got_wd.size() != 0 || imem_we !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_flush: got %0d writes we=%b busy=%b required 0/0/0", got_wd.size(), imem_we, busy);
      end
   endtask

   task automatic test_random;
      int w;
      int n;
      for (int s = 0; s < 6; s++) begin
         wr_mode = 2;
         start_session(6'($urandom), 1'b0);
         n = $urandom_range(1, 12);
         for (int i = 0; i < n; i++) begin
            do_req(4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom),
                   16'($urandom), 26'($urandom));
            if ($urandom_range(0, 3) == 0) begin
               @(posedge clk);
               #1;
            end
         end
         end_session(w);
         checks++;
         if (got_wd.size() != exp_wd.size()) begin
            errors++;
            $display("FAIL rnd%0d_count: got %0d writes required %0d", s, got_wd.size(), exp_wd.size());
         end else begin
            foreach (exp_wd[i]) begin
               checks++;
               if (got_wd[i] !== exp_wd[i] || got_addr[i] !== exp_addr[i]) begin
                  errors++;
                  $display("FAIL rnd%0d_word%0d: got %h@%0d required %h@%0d", s, i, got_wd[i], got_addr[i],
                           exp_wd[i], exp_addr[i]);
               end
            end
         end
         checks++;
         if (err !== m_err || wrapped !== m_wrap || w !== 1) begin
            errors++;
            $display("FAIL rnd%0d_flags: got err=%b wrapped=%b done_width=%0d required %b/%b/1",
                     s, err, wrapped, w, m_err, m_wrap);
         end
      end
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      base = '0;
      finish = 1'b0;
      req_valid = 1'b0;
      req_kind = '0;
      req_rs = '0;
      req_rt = '0;
      req_rd = '0;
      req_imm = '0;
      req_target = '0;
      test_reset();
      test_add();
      test_sequence();
      test_backpressure();
      test_illegal();
      test_wrap();
      test_reset_mid_drain();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
